// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Takes a byte stream made of a 16-bit word count N (high byte first)
// followed by N big-endian 32-bit words. It writes the words to
// instruction memory at sequential addresses starting at 0, and holds the
// CPU stalled until the whole image is in memory.
module imem_loader #(
    parameter int unsigned DEPTH = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        overflow,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // 17 bits so that the full 64K depth can be represented
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    // True when a word index addresses a real memory location
    function automatic logic in_range(input logic [15:0] idx);
        return ({1'b0, idx} < DEPTH_L);
    endfunction

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] words_q, words_d;
    logic        mem_we_q, mem_we_d;
    logic        done_q, done_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        overflow_q, overflow_d;
    logic        ready_s;
    logic        xfer_s;
    logic [15:0] len_lo_s;
    logic [15:0] idx_next_s;

    // The loader may take a byte only in the length or data phases
    assign ready_s    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
    assign xfer_s     = ready_s && byte_valid;
    assign len_lo_s   = {len_q[15:8], byte_data};
    assign idx_next_s = idx_q + 16'd1;

    // Next-state and next-output computation for the load sequence
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        idx_d      = idx_q;
        words_d    = words_q;
        overflow_d = overflow_q;
        mem_we_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                // a start from either resting state begins a fresh load
                if (start) begin
                    state_d    = S_LEN_HI;
                    idx_d      = 16'd0;
                    words_d    = 16'd0;
                    overflow_d = 1'b0;
                    cnt_d      = 2'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN_HI: begin
                if (xfer_s) begin
                    len_d   = {byte_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (xfer_s) begin
                    len_d = len_lo_s;
                    cnt_d = 2'd0;
                    if (len_lo_s == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    word_d = {word_q[23:0], byte_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // the write strobe is registered so it lines up with WRITE
                        state_d  = S_WRITE;
                        mem_we_d = in_range(idx_q);
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_WRITE: begin
                if (in_range(idx_q)) begin
                    words_d = words_q + 16'd1;
                end else begin
                    overflow_d = 1'b1;
                end
                idx_d = idx_next_s;
                if (idx_next_s == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        done_d     = (state_d == S_DONE);
        cpu_hold_d = (state_d != S_DONE);
    end

    // State and registered outputs; an abort via rst_n returns everything to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            cnt_q      <= 2'd0;
            word_q     <= 32'd0;
            idx_q      <= 16'd0;
            words_q    <= 16'd0;
            mem_we_q   <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            words_q    <= words_d;
            mem_we_q   <= mem_we_d;
            done_q     <= done_d;
            cpu_hold_q <= cpu_hold_d;
            overflow_q <= overflow_d;
        end
    end

    assign byte_ready   = ready_s;
    assign mem_we       = mem_we_q;
    assign mem_addr     = idx_q;
    assign mem_wdata    = word_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader. Two instances share one stream: one at full depth
// and one with DEPTH=2, which exercises the out-of-range path. Expected
// writes go into per-instance queues when a word is driven. A monitor pops
// and compares an entry on every write strobe it sees.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_valid = 1'b0;

    logic        byte_ready0, mem_we0, cpu_hold0, done0, overflow0;
    logic [15:0] mem_addr0, words0;
    logic [31:0] mem_wdata0;
    logic        byte_ready1, mem_we1, cpu_hold1, done1, overflow1;
    logic [15:0] mem_addr1, words1;
    logic [31:0] mem_wdata1;

    int vecs  = 0;
    int fails = 0;
    logic [47:0] q0[$];
    logic [47:0] q1[$];

    imem_loader #(.DEPTH(65536)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .cpu_hold(cpu_hold0),
        .done(done0), .overflow(overflow0), .words_loaded(words0)
    );

    imem_loader #(.DEPTH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .cpu_hold(cpu_hold1),
        .done(done1), .overflow(overflow1), .words_loaded(words1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the full-depth instance
    always @(negedge clk) begin
        if (rst_n && mem_we0) begin
            check("d0 write expected", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) begin
                logic [47:0] e;
                e = q0.pop_front();
                check("d0 mem_addr", 32'(mem_addr0), 32'(e[47:32]));
                check("d0 mem_wdata", mem_wdata0, e[31:0]);
                check("d0 ready in WRITE", 32'(byte_ready0), 32'd0);
            end
        end
    end

    // Scoreboard for the two-word instance
    always @(negedge clk) begin
        if (rst_n && mem_we1) begin
            check("d1 write expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) begin
                logic [47:0] e;
                e = q1.pop_front();
                check("d1 mem_addr", 32'(mem_addr1), 32'(e[47:32]));
                check("d1 mem_wdata", mem_wdata1, e[31:0]);
                check("d1 ready in WRITE", 32'(byte_ready1), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready wait", 32'(byte_ready0), 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic expect_word(input int idx, input logic [31:0] w);
        if (idx < 65536) q0.push_back({16'(idx), w});
        if (idx < 2)     q1.push_back({16'(idx), w});
    endtask

    task automatic send_word(input int idx, input logic [31:0] w, input bit gap);
        expect_word(idx, w);
        for (int i = 0; i < 4; i++) send_byte(w[31 - 8*i -: 8], gap);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, " byte_ready"}, 32'(byte_ready0), 32'd0);
        check({tag, " mem_we"}, 32'(mem_we0), 32'd0);
        check({tag, " mem_addr"}, 32'(mem_addr0), 32'd0);
        check({tag, " mem_wdata"}, mem_wdata0, 32'd0);
        check({tag, " done"}, 32'(done0), 32'd0);
        check({tag, " cpu_hold"}, 32'(cpu_hold0), 32'd1);
        check({tag, " overflow"}, 32'(overflow1), 32'd0);
        check({tag, " words"}, 32'(words0), 32'd0);
    endtask

    initial begin
        // reset values
        #12;
        check_idle_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // T1: two words, valid held high
        pulse_start();
        check("t1 ready after start", 32'(byte_ready0), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(0, 32'h12345678, 1'b0);
        send_word(1, 32'h9ABCDEF0, 1'b0);
        check("t1 mem_we after last byte", 32'(mem_we0), 32'd1);
        check("t1 done not yet", 32'(done0), 32'd0);
        @(posedge clk);
        #1;
        check("t1 done", 32'(done0), 32'd1);
        check("t1 cpu_hold", 32'(cpu_hold0), 32'd0);
        check("t1 words", 32'(words0), 32'd2);
        check("t1 overflow", 32'(overflow0), 32'd0);

        // T2: same stream with valid toggling
        pulse_start();
        check("t2 done dropped", 32'(done0), 32'd0);
        check("t2 cpu_hold raised", 32'(cpu_hold0), 32'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(0, 32'h12345678, 1'b1);
        send_word(1, 32'h9ABCDEF0, 1'b1);
        @(posedge clk);
        #1;
        check("t2 done", 32'(done0), 32'd1);
        check("t2 words", 32'(words0), 32'd2);

        // T3: empty image
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("t3 done", 32'(done0), 32'd1);
        check("t3 cpu_hold", 32'(cpu_hold0), 32'd0);
        check("t3 words", 32'(words0), 32'd0);

        // T4: three words, DEPTH=2 instance overflows on the third
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_word(0, 32'hA5A5_0001, 1'b0);
        send_word(1, 32'h5A5A_0002, 1'b1);
        send_word(2, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        #1;
        check("t4 d0 done", 32'(done0), 32'd1);
        check("t4 d1 done", 32'(done1), 32'd1);
        check("t4 d0 words", 32'(words0), 32'd3);
        check("t4 d1 words", 32'(words1), 32'd2);
        check("t4 d0 overflow", 32'(overflow0), 32'd0);
        check("t4 d1 overflow", 32'(overflow1), 32'd1);

        // T6: restart clears state; a start during DATA is ignored
        pulse_start();
        check("t6 done dropped", 32'(done1), 32'd0);
        check("t6 cpu_hold", 32'(cpu_hold1), 32'd1);
        check("t6 overflow cleared", 32'(overflow1), 32'd0);
        check("t6 words cleared", 32'(words1), 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        expect_word(0, 32'hCAFE_F00D);
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        pulse_start();
        check("t6 ready after ignored start", 32'(byte_ready1), 32'd1);
        check("t6 hold during load", 32'(cpu_hold0), 32'd1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h0D, 1'b0);
        check("t6 hold in WRITE", 32'(cpu_hold0), 32'd1);
        @(posedge clk);
        #1;
        check("t6 done", 32'(done0), 32'd1);
        check("t6 words", 32'(words1), 32'd1);
        check("t6 overflow", 32'(overflow1), 32'd0);

        // T5: reset during the 3rd byte of word 1, then a clean reload
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(0, 32'h1111_2222, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        byte_data  = 8'h55;
        byte_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_reset("t5 abort");
        byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(0, 32'h0BAD_F00D, 1'b0);
        send_word(1, 32'h7654_3210, 1'b1);
        @(posedge clk);
        #1;
        check("t5 done", 32'(done0), 32'd1);
        check("t5 words", 32'(words0), 32'd2);

        @(negedge clk);
        check("q0 drained", 32'(q0.size()), 32'd0);
        check("q1 drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
